// File: rtl/stv_cart_line_buf.sv
// Single-line (32-byte) read-only cache between the ST-V cart A-bus port and the
// DDR3 ROM store. Misses refill the line with one 4-beat 64-bit burst.
module stv_cart_line_buf #(
  parameter logic [28:0] BASE_WADDR = 29'h0400000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RES_N,
  input  logic        INVAL,
  input  logic [25:1] REQ_A,
  input  logic        REQ_RD,
  output logic [15:0] REQ_DO,
  output logic        REQ_RDY,
  output logic [28:0] DDR_ADDR,
  output logic [7:0]  DDR_BURSTCNT,
  output logic        DDR_RD,
  input  logic        DDR_BUSY,
  input  logic [63:0] DDR_DOUT,
  input  logic        DDR_DOUT_READY,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_FILL  = 3'd2,
    S_RESP  = 3'd3,
    S_HOLD  = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] line_q [4];
  logic [25:5] tag_q;
  logic [25:5] line_addr_q;
  logic        valid_q;
  logic        fill_inval_q;
  logic [1:0]  cnt_q;
  logic [28:0] ddr_addr_q;
  logic [15:0] req_do_q;

  logic        hit;
  logic        last_beat;
  logic        miss_start;
  logic        resp_fire;
  logic [28:0] miss_addr;
  logic [63:0] beat_sel;
  logic [15:0] resp_do;

  assign hit        = valid_q && (tag_q == REQ_A[25:5]);
  assign last_beat  = DDR_DOUT_READY && (cnt_q == 2'd3);
  assign miss_start = (state_q == S_IDLE) && RES_N && REQ_RD && !hit;
  assign resp_fire  = (state_q == S_RESP) && RES_N;
  assign miss_addr  = BASE_WADDR + {6'd0, REQ_A[25:5], 2'b00};
  assign beat_sel   = line_q[REQ_A[4:3]];
  assign resp_do    = beat_sel[{REQ_A[2:1], 4'b0000} +: 16];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A soft reset that lands after the burst was accepted must still swallow
  // the remaining beats, otherwise they would corrupt the next fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (RES_N && REQ_RD) state_d = hit ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (!DDR_BUSY)  state_d = RES_N ? S_FILL : S_DRAIN;
        else if (!RES_N) state_d = S_IDLE;
      end
      S_FILL: begin
        if (last_beat)   state_d = RES_N ? S_RESP : S_IDLE;
        else if (!RES_N) state_d = S_DRAIN;
      end
      S_RESP:  state_d = RES_N ? S_HOLD : S_IDLE;
      S_HOLD:  state_d = S_IDLE;
      S_DRAIN: begin
        if (last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    DDR_RD       = (state_q == S_ISSUE);
    REQ_RDY      = resp_fire;
    REQ_DO       = resp_fire ? resp_do : req_do_q;
    DDR_ADDR     = ddr_addr_q;
    DDR_BURSTCNT = 8'd4;
    DBG_STATE    = state_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q      <= 1'b0;
      fill_inval_q <= 1'b0;
      tag_q        <= '0;
      line_addr_q  <= '0;
      cnt_q        <= 2'd0;
      ddr_addr_q   <= '0;
      req_do_q     <= '0;
    end else begin
      if (miss_start) begin
        line_addr_q  <= REQ_A[25:5];
        ddr_addr_q   <= miss_addr;
        cnt_q        <= 2'd0;
        valid_q      <= 1'b0;
        fill_inval_q <= 1'b0;
      end
      if ((state_q == S_FILL || state_q == S_DRAIN) && DDR_DOUT_READY)
        cnt_q <= cnt_q + 2'd1;
      if (state_q == S_FILL && last_beat && RES_N) begin
        tag_q   <= line_addr_q;
        valid_q <= !(fill_inval_q || INVAL);
      end
      if (resp_fire)
        req_do_q <= resp_do;
      // An invalidate seen anywhere during a fill keeps the refilled line invalid.
      if (INVAL) begin
        valid_q      <= 1'b0;
        fill_inval_q <= 1'b1;
      end
      if (!RES_N)
        valid_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == S_FILL && DDR_DOUT_READY && RES_N)
      line_q[cnt_q] <= DDR_DOUT;
  end

endmodule
